alu_share_ctrl: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/alu_share_ctrl_if.sv | 37 +++
 rtl/alu_seq_div.sv | 83 ++++++++
 rtl/alu_share_ctrl.sv | 139 +++++++++++++
 tb/tb_alu_share_ctrl.sv | 257 +++++++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// Shared opcodes, default operand width and controller state encoding for the
// shared-ALU controller.
package alu_pkg;

  localparam int unsigned OPW_DEFAULT = 4;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;
  localparam logic [2:0] OP_MUL = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;

  typedef enum logic [1:0] {
    IDLE,
    DIV,
    RESP
  } state_e;

endpackage

// File: rtl/alu_share_ctrl_if.sv
// Two request channels and one held response channel of the shared ALU.
interface alu_share_ctrl_if #(
  parameter int unsigned OPW = alu_pkg::OPW_DEFAULT
);
  logic             req0_valid;
  logic             req0_ready;
  logic [2:0]       req0_op;
  logic [OPW-1:0]   req0_a;
  logic [OPW-1:0]   req0_b;
  logic             req1_valid;
  logic             req1_ready;
  logic [2:0]       req1_op;
  logic [OPW-1:0]   req1_a;
  logic [OPW-1:0]   req1_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic             rsp_id;
  logic [2*OPW-1:0] rsp_data;
  logic             rsp_err;
  logic             busy;

  modport slave (
    input  req0_valid, req0_op, req0_a, req0_b,
    input  req1_valid, req1_op, req1_a, req1_b,
    input  rsp_ready,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );

  modport master (
    output req0_valid, req0_op, req0_a, req0_b,
    output req1_valid, req1_op, req1_a, req1_b,
    output rsp_ready,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/alu_seq_div.sv
// Iterative restoring divider: one quotient bit per clock, OPW steps after start,
// done raised the edge after the last step. b=0 yields quo=all ones, rem=a.
module alu_seq_div
  import alu_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEFAULT
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [OPW-1:0] a,
  input  logic [OPW-1:0] b,
  output logic           done,
  output logic [OPW-1:0] quo,
  output logic [OPW-1:0] rem,
  output logic           dz
);

  localparam int unsigned CW = (OPW > 1) ? $clog2(OPW) : 1;

  logic [OPW-1:0] rem_q, rem_d, quo_q, quo_d, div_q, div_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           active_q, active_d, done_q, done_d, dz_q, dz_d;
  logic [OPW:0]   rem_sh;
  logic           fits;

  assign rem_sh = {rem_q, quo_q[OPW-1]};
  assign fits   = rem_sh >= {1'b0, div_q};

  always_comb begin
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    active_d = active_q;
    done_d   = done_q;
    dz_d     = dz_q;
    if (start) begin
      rem_d    = '0;
      quo_d    = a;
      div_d    = b;
      cnt_d    = CW'(OPW - 1);
      active_d = 1'b1;
      done_d   = 1'b0;
      dz_d     = (b == '0);
    end else if (active_q) begin
      // Dividend bits shift out of quo while quotient bits shift in.
      rem_d = OPW'(fits ? rem_sh - {1'b0, div_q} : rem_sh);
      quo_d = {quo_q[OPW-2:0], fits};
      cnt_d = cnt_q - 1'b1;
      if (cnt_q == '0) begin
        active_d = 1'b0;
        done_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      active_q <= active_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign done = done_q;
  assign quo  = quo_q;
  assign rem  = rem_q;
  assign dz   = dz_q;

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin sharing of one ALU between two requesters with a held response;
// single-cycle ops finish on the accept edge, DIV uses the sequential divider.
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned OPW = OPW_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  alu_share_ctrl_if.slave  bus
);

  localparam int unsigned RW        = 2 * OPW;
  localparam int unsigned DIV_ITERS = OPW;

  state_e         state_q, state_d;
  logic           last_grant_q, last_grant_d;
  logic           rsp_valid_q, rsp_valid_d;
  logic           rsp_id_q, rsp_id_d;
  logic           rsp_err_q, rsp_err_d;
  logic [RW-1:0]  rsp_data_q, rsp_data_d;

  logic           idle, grant0, grant1, accept, div_start;
  logic [2:0]     sel_op;
  logic [OPW-1:0] sel_a, sel_b;
  logic [RW-1:0]  ea, eb, alu_res;
  logic           alu_err;
  logic           div_done, div_dz;
  logic [OPW-1:0] div_quo, div_rem;

  // On contention the requester that did not win last time is served.
  assign idle   = (state_q == IDLE);
  assign grant0 = bus.req0_valid & (~bus.req1_valid | last_grant_q);
  assign grant1 = bus.req1_valid & (~bus.req0_valid | ~last_grant_q);
  assign accept = idle & (grant0 | grant1);

  assign bus.req0_ready = idle & grant0;
  assign bus.req1_ready = idle & grant1;

  assign sel_op    = grant1 ? bus.req1_op : bus.req0_op;
  assign sel_a     = grant1 ? bus.req1_a  : bus.req0_a;
  assign sel_b     = grant1 ? bus.req1_b  : bus.req0_b;
  assign div_start = accept & (sel_op == OP_DIV);
  assign ea        = RW'(sel_a);
  assign eb        = RW'(sel_b);

  always_comb begin
    alu_res = '0;
    alu_err = 1'b0;
    case (sel_op)
      OP_AND:  alu_res = ea & eb;
      OP_OR:   alu_res = ea | eb;
      OP_ADD:  alu_res = ea + eb;
      OP_SUB:  alu_res = ea - eb;
      OP_MUL:  alu_res = ea * eb;
      OP_DIV:  alu_res = '0;
      default: alu_err = 1'b1;
    endcase
  end

  alu_seq_div #(
    .OPW (DIV_ITERS)
  ) u_div (
    .clk   (clk),
    .rst   (rst),
    .start (div_start),
    .a     (sel_a),
    .b     (sel_b),
    .done  (div_done),
    .quo   (div_quo),
    .rem   (div_rem),
    .dz    (div_dz)
  );

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_id_d     = rsp_id_q;
    rsp_err_d    = rsp_err_q;
    rsp_data_d   = rsp_data_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          last_grant_d = grant1;
          rsp_id_d     = grant1;
          if (sel_op == OP_DIV) begin
            state_d = DIV;
          end else begin
            state_d     = RESP;
            rsp_valid_d = 1'b1;
            rsp_data_d  = alu_res;
            rsp_err_d   = alu_err;
          end
        end
      end
      DIV: begin
        if (div_done) begin
          state_d     = RESP;
          rsp_valid_d = 1'b1;
          rsp_data_d  = {div_rem, div_quo};
          rsp_err_d   = div_dz;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d     = IDLE;
          rsp_valid_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      rsp_valid_q  <= 1'b0;
      rsp_id_q     <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_id_q     <= rsp_id_d;
      rsp_err_q    <= rsp_err_d;
      rsp_data_q   <= rsp_data_d;
    end
  end

  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_data  = rsp_data_q;
  assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: reset/abort, per-opcode results and
// latency, round-robin arbitration and response backpressure.
module tb_alu_share_ctrl;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  alu_share_ctrl_if #(.OPW(4)) bus ();

  alu_share_ctrl #(
    .OPW (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // edges: clock edges after the accept edge before rsp_valid is seen; single-cycle
  // ops register the response on the accept edge itself, DIV needs DIV_ITERS+1 edges.
  typedef struct packed {
    logic       id;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
    logic       err;
    int         edges;
  } vec_t;

  localparam int NV = 10;
  localparam vec_t VECS [NV] = '{
    '{1'b0, 3'b010, 4'd9,  4'd8,  8'h11, 1'b0, 0},
    '{1'b1, 3'b011, 4'd3,  4'd5,  8'hFE, 1'b0, 0},
    '{1'b1, 3'b100, 4'd15, 4'd15, 8'hE1, 1'b0, 0},
    '{1'b0, 3'b101, 4'd13, 4'd4,  8'h13, 1'b0, 5},
    '{1'b0, 3'b101, 4'd7,  4'd0,  8'h7F, 1'b1, 5},
    '{1'b1, 3'b000, 4'hC,  4'hA,  8'h08, 1'b0, 0},
    '{1'b0, 3'b001, 4'hC,  4'hA,  8'h0E, 1'b0, 0},
    '{1'b1, 3'b111, 4'd5,  4'd5,  8'h00, 1'b1, 0},
    '{1'b0, 3'b110, 4'd15, 4'd15, 8'h00, 1'b1, 0},
    '{1'b1, 3'b101, 4'd15, 4'd1,  8'h0F, 1'b0, 5}
  };

  task automatic quiet_inputs();
    bus.req0_valid = 1'b0; bus.req0_op = 3'b000; bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_op = 3'b000; bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp_ready  = 1'b1;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1;
    quiet_inputs();
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data} !== 11'd0) begin
      failures++;
      $display("FAIL reset_rsp: got v=%b id=%b err=%b data=%h, want all 0",
               bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data);
    end
    checks++;
    if ({bus.busy, bus.req0_ready, bus.req1_ready} !== 3'b000) begin
      failures++;
      $display("FAIL reset_busy_ready: got busy/r0/r1=%b%b%b, want 000",
               bus.busy, bus.req0_ready, bus.req1_ready);
    end
    // Start a DIV, then reset while it iterates.
    @(posedge clk); #1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_DIV; bus.req0_a = 4'd13; bus.req0_b = 4'd4;
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL abort_accept: got req0_ready=%b, want 1", bus.req0_ready);
    end
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++;
      $display("FAIL abort_busy_div: got busy=%b, want 1", bus.busy);
    end
    @(posedge clk); #1 rst = 1'b1;
    #1;
    checks++;
    if ({bus.busy, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err} !== 12'd0) begin
      failures++;
      $display("FAIL abort_async: got busy=%b v=%b data=%h id=%b err=%b, want all 0",
               bus.busy, bus.rsp_valid, bus.rsp_data, bus.rsp_id, bus.rsp_err);
    end
    @(posedge clk); #1 rst = 1'b0;
    seen = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (bus.rsp_valid === 1'b1 || bus.busy === 1'b1) seen++;
    end
    checks++;
    if (seen !== 0) begin
      failures++;
      $display("FAIL abort_no_rsp: got %0d cycles with valid/busy, want 0", seen);
    end
  endtask

  task automatic test_arbitration();
    logic       exp_id;
    logic [7:0] exp_data;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 4'hF; bus.req0_b = 4'h3;
    bus.req1_valid = 1'b1; bus.req1_op = OP_AND; bus.req1_a = 4'hF; bus.req1_b = 4'hC;
    for (int k = 0; k < 6; k++) begin
      exp_id   = k[0];
      exp_data = exp_id ? 8'h0C : 8'h03;
      @(negedge clk);
      checks++;
      if ({bus.req0_ready, bus.req1_ready} !== {~exp_id, exp_id}) begin
        failures++;
        $display("FAIL arb_grant[%0d]: got r0/r1=%b%b, want %b%b",
                 k, bus.req0_ready, bus.req1_ready, ~exp_id, exp_id);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {1'b1, exp_id, exp_data}) begin
        failures++;
        $display("FAIL arb_rsp[%0d]: got v=%b id=%b data=%h, want v=1 id=%b data=%h",
                 k, bus.rsp_valid, bus.rsp_id, bus.rsp_data, exp_id, exp_data);
      end
      @(posedge clk); #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
        failures++;
        $display("FAIL arb_single_rsp[%0d]: got rsp_valid=%b, want 0", k, bus.rsp_valid);
      end
    end
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic test_ops();
    vec_t v;
    int   n;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      v = VECS[i];
      if (v.id) begin
        bus.req1_valid = 1'b1; bus.req1_op = v.op; bus.req1_a = v.a; bus.req1_b = v.b;
      end else begin
        bus.req0_valid = 1'b1; bus.req0_op = v.op; bus.req0_a = v.a; bus.req0_b = v.b;
      end
      @(negedge clk);
      checks++;
      if ((v.id ? bus.req1_ready : bus.req0_ready) !== 1'b1) begin
        failures++;
        $display("FAIL op_ready[%0d]: got ready=0/x, want 1 for requester %0d", i, v.id);
      end
      @(posedge clk); #1;
      bus.req0_valid = 1'b0;
      bus.req1_valid = 1'b0;
      n = 0;
      while (bus.rsp_valid !== 1'b1 && n < 20) begin
        @(posedge clk); #1;
        n++;
      end
      checks++;
      if (n !== v.edges) begin
        failures++;
        $display("FAIL op_latency[%0d]: got %0d edges, want %0d", i, n, v.edges);
      end
      checks++;
      if ({bus.rsp_data, bus.rsp_id, bus.rsp_err} !== {v.data, v.id, v.err}) begin
        failures++;
        $display("FAIL op_result[%0d]: got data=%h id=%b err=%b, want data=%h id=%b err=%b",
                 i, bus.rsp_data, bus.rsp_id, bus.rsp_err, v.data, v.id, v.err);
      end
      @(posedge clk); #1;
      checks++;
      if ({bus.rsp_valid, bus.busy} !== 2'b00) begin
        failures++;
        $display("FAIL op_release[%0d]: got v=%b busy=%b, want 0 0",
                 i, bus.rsp_valid, bus.busy);
      end
    end
  endtask

  task automatic test_backpressure();
    bus.rsp_ready  = 1'b0;
    bus.req1_valid = 1'b1; bus.req1_op = OP_MUL; bus.req1_a = 4'd6; bus.req1_b = 4'd7;
    @(negedge clk);
    checks++;
    if (bus.req1_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_accept: got req1_ready=%b, want 1", bus.req1_ready);
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    bus.req0_valid = 1'b1; bus.req0_op = OP_AND; bus.req0_a = 4'hF; bus.req0_b = 4'hF;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      checks++;
      if ({bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data,
           bus.req0_ready, bus.req1_ready, bus.busy} !== {3'b110, 8'h2A, 3'b001}) begin
        failures++;
        $display("FAIL bp_hold[%0d]: got v=%b id=%b err=%b data=%h r0=%b r1=%b busy=%b",
                 c, bus.rsp_valid, bus.rsp_id, bus.rsp_err, bus.rsp_data,
                 bus.req0_ready, bus.req1_ready, bus.busy);
      end
      @(posedge clk); #1;
      bus.req0_a = 4'(c);
      bus.req0_op = 3'(c);
    end
    bus.req0_op = OP_AND; bus.req0_a = 4'd5; bus.req0_b = 4'd6;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.rsp_valid !== 1'b0) begin
      failures++;
      $display("FAIL bp_consume: got rsp_valid=%b, want 0", bus.rsp_valid);
    end
    @(negedge clk);
    checks++;
    if (bus.req0_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_next_ready: got req0_ready=%b, want 1", bus.req0_ready);
    end
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    checks++;
    if ({bus.rsp_valid, bus.rsp_id, bus.rsp_data} !== {2'b10, 8'h04}) begin
      failures++;
      $display("FAIL bp_next_rsp: got v=%b id=%b data=%h, want v=1 id=0 data=04",
               bus.rsp_valid, bus.rsp_id, bus.rsp_data);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_arbitration();
    test_ops();
    test_backpressure();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, want completion");
    $fatal(1, "watchdog");
  end

endmodule
